// File: rtl/engine_tick_scheduler.sv
// ---------------------------------------------------------------------------
// engine_tick_scheduler
//
// Runs the DSP engine once per received audio frame. A rising edge on
// sample_valid is one frame event. In the normal path the sample is
// registered into engine_in and the engine gets a one-cycle tick. The
// scheduler then ignores engine_ready for a guard window, because the engine
// drops ready a few cycles late. After that it waits for ready and latches
// engine_out into sample_out for the I2S transmitter.
//
// Frames that arrive while a pass is in flight, or while the engine reports
// not-ready, are dropped. Each dropped frame gives a one-cycle overrun pulse
// and bumps a saturating counter. Bypass routes a frame straight to
// sample_out without touching the engine.
//
// Optional feature: define ENGINE_WATCHDOG_EN to add a WAIT-state watchdog.
// If the engine never becomes ready within TIMEOUT_CYCLES WAIT cycles, the
// pass is abandoned, the output is muted and a sticky timeout_flag is set.
// Without the macro, WAIT lasts until engine_ready and timeout_flag is 0.
//
// Parameters
//   DATA_WIDTH     sample width in bits
//   GUARD_CYCLES   cycles after the tick during which engine_ready is ignored
//   TIMEOUT_CYCLES watchdog limit in WAIT cycles (watchdog build only)
//   CNT_WIDTH      overrun counter width
//
// Ports
//   sys_clk        in   system clock
//   reset          in   synchronous, active-high reset
//   sample_valid   in   frame valid level from the I2S receiver
//   sample_in      in   received sample, stable while sample_valid is high
//   engine_ready   in   DSP engine idle/done
//   engine_out     in   DSP engine result
//   bypass         in   1 = pass sample_in straight to sample_out
//   clear_status   in   one-cycle pulse clearing overrun_count/timeout_flag
//   tick_engine    out  one-cycle pulse starting an engine pass
//   engine_in      out  registered sample presented to the engine
//   sample_out     out  registered sample for the I2S transmitter
//   busy           out  high whenever a pass is in progress
//   overrun        out  one-cycle pulse per dropped frame
//   overrun_count  out  dropped-frame count, saturating at all-ones
//   timeout_flag   out  sticky watchdog flag
// ---------------------------------------------------------------------------
module engine_tick_scheduler #(
    parameter int DATA_WIDTH     = 16,
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  engine_ready,
    input  logic [DATA_WIDTH-1:0] engine_out,
    input  logic                  bypass,
    input  logic                  clear_status,
    output logic                  tick_engine,
    output logic [DATA_WIDTH-1:0] engine_in,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  busy,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  overrun_count,
    output logic                  timeout_flag
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TICK  = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    state_t                         state_q, state_d;
    logic                           valid_q;
    logic [GW-1:0]                  guard_q, guard_d;
    logic signed [DATA_WIDTH-1:0]   engine_in_q, engine_in_d;
    logic signed [DATA_WIDTH-1:0]   sample_out_q, sample_out_d;
    logic                           overrun_q;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic                           frame_evt;
    logic                           drop;

`ifdef ENGINE_WATCHDOG_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [WW-1:0] wd_q, wd_d;
    logic          tflag_q, tflag_d;
    logic          wd_hit;
`endif

    // A level held high is a single event: only the low-to-high transition counts.
    assign frame_evt = sample_valid & ~valid_q;

    // ---- next-state / datapath selection ----
    always_comb begin
        state_d      = state_q;
        guard_d      = guard_q;
        engine_in_d  = engine_in_q;
        sample_out_d = sample_out_q;
        drop         = 1'b0;
`ifdef ENGINE_WATCHDOG_EN
        wd_hit       = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (frame_evt) begin
                    if (bypass) begin
                        sample_out_d = sample_in;
                    end else if (engine_ready) begin
                        engine_in_d = sample_in;
                        state_d     = S_TICK;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end

            S_TICK: begin
                guard_d = '0;
                state_d = (GUARD_CYCLES > 0) ? S_GUARD : S_WAIT;
            end

            // engine_ready may still show the previous "idle" level here.
            S_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end

            S_WAIT: begin
                // A ready arriving on the final watchdog cycle still wins.
                if (engine_ready) begin
                    sample_out_d = engine_out;
                    state_d      = S_IDLE;
                end
`ifdef ENGINE_WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    sample_out_d = '0;
                    wd_hit       = 1'b1;
                    state_d      = S_IDLE;
                end
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frames arriving mid-pass are dropped; the pass itself is unaffected.
        if (frame_evt && (state_q != S_IDLE)) begin
            drop = 1'b1;
        end

        // Clear takes effect first, so a coincident drop leaves the count at 1.
        cnt_d = clear_status ? '0 : cnt_q;
        if (drop) begin
            cnt_d = sat_inc(cnt_d);
        end
    end

    // ---- registers ----
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= 1'b0;
            guard_q      <= '0;
            engine_in_q  <= '0;
            sample_out_q <= '0;
            overrun_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= sample_valid;
            guard_q      <= guard_d;
            engine_in_q  <= engine_in_d;
            sample_out_q <= sample_out_d;
            overrun_q    <= drop;
            cnt_q        <= cnt_d;
        end
    end

`ifdef ENGINE_WATCHDOG_EN
    // ---- watchdog ----
    // The counter is held at zero outside WAIT, so it restarts on every WAIT entry.
    always_comb begin
        wd_d    = (state_q == S_WAIT) ? wd_q + 1'b1 : '0;
        tflag_d = clear_status ? 1'b0 : tflag_q;
        if (wd_hit) begin
            tflag_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wd_q    <= '0;
            tflag_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            tflag_q <= tflag_d;
        end
    end

    assign timeout_flag = tflag_q;
`else
    // No watchdog: the flag is constant 0. TIMEOUT_CYCLES is never negative,
    // so this term is always false and keeps the parameter referenced.
    assign timeout_flag = (TIMEOUT_CYCLES < 0);
`endif

    // ---- outputs ----
    assign tick_engine   = (state_q == S_TICK);
    assign busy          = (state_q != S_IDLE);
    assign engine_in     = engine_in_q;
    assign sample_out    = sample_out_q;
    assign overrun       = overrun_q;
    assign overrun_count = cnt_q;

endmodule
